// File: rtl/wall_clock_core.sv
`default_nettype none
// ============================================================================
// Module   : wall_clock_core
// Brief    : 24 h BCD timekeeping with settable time/alarm, alarm ringer and
//            packed 8-digit nibble word for the seven-segment multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
module wall_clock_core #(
    parameter int TICK_DIV  = 100000000,
    parameter int RING_SECS = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode_pulse,
    input  logic        inc_pulse,
    input  logic        alarm_en,
    output logic [31:0] to_display,
    output logic        alarm_ring,
    output logic        tick
);

    localparam int c_PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_RING_W = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
    localparam logic [c_PRE_W-1:0]  c_PRE_MAX  = c_PRE_W'(TICK_DIV - 1);
    localparam logic [c_RING_W-1:0] c_RING_MAX = c_RING_W'(RING_SECS - 1);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_HR   = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_AHR  = 3'd3,
        ST_SET_AMIN = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_PRE_W-1:0]    r_pre;
    logic [7:0]            r_hr, r_min, r_sec, r_ahr, r_amin;
    logic [7:0]            w_hr_nxt, w_min_nxt, w_sec_nxt, w_ahr_nxt, w_amin_nxt;
    logic                  r_ring;
    logic [c_RING_W-1:0]   r_ring_cnt;
    logic [31:0]           r_display;
    logic [23:0]           w_disp_time;
    logic                  w_mode, w_inc, w_time_run, w_clr_sec, w_match;

    // Two-digit BCD increment that wraps from max back to 00.
    function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        else if (v[3:0] == 4'h9)
            return {v[7:4] + 4'h1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'h1};
    endfunction

    assign tick       = (r_pre == c_PRE_MAX);
    // While ringing, any pulse only silences the alarm.
    assign w_mode     = mode_pulse & ~r_ring;
    assign w_inc      = inc_pulse & ~mode_pulse & ~r_ring;
    assign w_time_run = tick & ((r_state == ST_RUN) | (r_state == ST_SET_AHR) |
                                (r_state == ST_SET_AMIN));
    assign w_clr_sec  = w_mode & (r_state == ST_SET_MIN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_RUN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_mode) begin
            case (r_state)
                ST_RUN:      w_state_nxt = ST_SET_HR;
                ST_SET_HR:   w_state_nxt = ST_SET_MIN;
                ST_SET_MIN:  w_state_nxt = ST_SET_AHR;
                ST_SET_AHR:  w_state_nxt = ST_SET_AMIN;
                default:     w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_comb begin
        w_sec_nxt  = r_sec;
        w_min_nxt  = r_min;
        w_hr_nxt   = r_hr;
        w_ahr_nxt  = r_ahr;
        w_amin_nxt = r_amin;
        if (w_time_run) begin
            w_sec_nxt = bcd_inc_wrap(r_sec, 8'h59);
            if (r_sec == 8'h59) begin
                w_min_nxt = bcd_inc_wrap(r_min, 8'h59);
                if (r_min == 8'h59)
                    w_hr_nxt = bcd_inc_wrap(r_hr, 8'h23);
            end
        end
        if (w_inc) begin
            case (r_state)
                ST_SET_HR:   w_hr_nxt   = bcd_inc_wrap(r_hr, 8'h23);
                ST_SET_MIN:  w_min_nxt  = bcd_inc_wrap(r_min, 8'h59);
                ST_SET_AHR:  w_ahr_nxt  = bcd_inc_wrap(r_ahr, 8'h23);
                ST_SET_AMIN: w_amin_nxt = bcd_inc_wrap(r_amin, 8'h59);
                default:     ;
            endcase
        end
        if (w_clr_sec)
            w_sec_nxt = 8'h00;
    end

    assign w_match = w_time_run & (r_state == ST_RUN) & alarm_en &
                     (w_hr_nxt == r_ahr) & (w_min_nxt == r_amin) & (w_sec_nxt == 8'h00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre  <= '0;
            r_hr   <= 8'h00;
            r_min  <= 8'h00;
            r_sec  <= 8'h00;
            r_ahr  <= 8'h00;
            r_amin <= 8'h00;
        end else begin
            if (w_clr_sec || tick)
                r_pre <= '0;
            else
                r_pre <= r_pre + 1'b1;
            r_hr   <= w_hr_nxt;
            r_min  <= w_min_nxt;
            r_sec  <= w_sec_nxt;
            r_ahr  <= w_ahr_nxt;
            r_amin <= w_amin_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ring     <= 1'b0;
            r_ring_cnt <= '0;
        end else if (r_ring) begin
            if (!alarm_en || mode_pulse || inc_pulse)
                r_ring <= 1'b0;
            else if (tick) begin
                if (r_ring_cnt == c_RING_MAX)
                    r_ring <= 1'b0;
                else
                    r_ring_cnt <= r_ring_cnt + 1'b1;
            end
        end else if (w_match) begin
            r_ring     <= 1'b1;
            r_ring_cnt <= '0;
        end
    end

    always_comb begin
        w_disp_time = {r_hr, r_min, r_sec};
        if ((r_state == ST_SET_AHR) || (r_state == ST_SET_AMIN))
            w_disp_time = {r_ahr, r_amin, 8'h00};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_display <= 32'h0000_0000;
        else
            r_display <= {w_disp_time, (alarm_en ? 4'hA : 4'h0), 1'b0, r_state};
    end

    assign to_display = r_display;
    assign alarm_ring = r_ring;

endmodule
`default_nettype wire
